wb_rr_arbiter: RTL
==================

Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone B3 arbiter. It shares one slave port, e.g. the main RAM, among NUM_MASTERS masters such as per-core data/instruction buses and the debug master.
- Grant is held for a master's whole cycle (cyc high), so registered-feedback bursts (cti/bte) are never split.
- Sits between the flattened per-core master buses and a single slave in the multi-core interconnect.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (>=2).
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 255, watchdog limit in cycles (8-bit counter); used only with the optional feature.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_n_i  in  1  synchronous active-low reset.
- m_adr_i  in  AW*NUM_MASTERS  master addresses; master k occupies slice [AW*(k+1)-1:AW*k]. All m_* buses use the same flattened slicing.
- m_dat_i  in  DW*NUM_MASTERS  master write data.
- m_sel_i  in  (DW/8)*NUM_MASTERS  byte selects.
- m_we_i  in  NUM_MASTERS  write enables.
- m_cyc_i  in  NUM_MASTERS  cycle requests.
- m_stb_i  in  NUM_MASTERS  strobes.
- m_cti_i  in  3*NUM_MASTERS  cycle type.
- m_bte_i  in  2*NUM_MASTERS  burst type.
- m_dat_o  out  DW*NUM_MASTERS  read data; the slave data is broadcast to every slice.
- m_ack_o  out  NUM_MASTERS  ack, to the granted master only.
- m_err_o  out  NUM_MASTERS  err, to the granted master only.
- m_rty_o  out  NUM_MASTERS  rty, to the granted master only.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_sel_o  out  DW/8  slave byte selects.
- s_we_o  out  1  slave write enable.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_cti_o  out  3  slave cycle type.
- s_bte_o  out  2  slave burst type.
- s_dat_i  in  DW  slave read data.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave err.
- s_rty_i  in  1  slave rty.
- grant_o  out  NUM_MASTERS  one-hot current grant, registered.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset is synchronous, active-low, on wb_rst_n_i; it is sampled on the rising edge.
- Reset state:
  - state=IDLE, grant_o=0, busy_o=0, last=NUM_MASTERS-1, so master 0 has first priority.
  - All s_* outputs 0; all m_ack_o, m_err_o, m_rty_o 0.
- Reset mid-transfer takes effect on the next edge, with the same values. No completion is issued to the aborted master.
- State IDLE:
  - If any m_cyc_i bit is set, select the first requester scanning from (last+1) mod NUM_MASTERS upward with wrap.
  - Register its one-hot grant, then go to GRANT.
  - Arbitration latency: exactly 1 cycle from cyc seen to s_cyc_o high.
- State GRANT:
  - s_* outputs are a combinational mux of the granted master's signals.
  - The slave's ack/err/rty are routed combinationally to the granted master's bit. All other masters' response bits are 0.
  - Non-granted masters stall with cyc/stb high and no response.
- Release:
  - Condition: the granted master's m_cyc_i is low.
  - Action: on that edge set last=granted index, clear grant_o, and return to IDLE. s_cyc_o is already low in that cycle through the mux.
  - Re-arbitration takes place in IDLE on the following cycle, so there is one dead cycle between owners.
- Bursts: cti=010 incrementing bursts are not interrupted. Grant changes only on a cyc drop, regardless of cti=111.
- Simultaneous requests: strict rotation. With all NUM_MASTERS requesting continuously, each master is granted once per NUM_MASTERS grants.
- A granted master that drops and re-raises cyc is re-arbitrated and may lose priority.
- Outputs when not in GRANT: s_cyc_o=s_stb_o=s_we_o=0. s_adr_o, s_dat_o, s_sel_o, s_cti_o and s_bte_o are driven 0.

Optional Feature:
- Macro: WB_RR_ARBITER_WATCHDOG_EN.
- Enabled:
  - An 8-bit counter runs in GRANT while s_stb_o=1 and (s_ack_i|s_err_i|s_rty_i)=0. It clears on any slave response or on state change.
  - When the counter reaches TIMEOUT, go to ABORT.
  - ABORT, first cycle: s_cyc_o/s_stb_o forced 0, m_err_o of the granted master pulsed for exactly 1 cycle.
  - ABORT then holds until the master drops cyc, and returns to IDLE with last=granted.
- Disabled: no counter, no ABORT state; a stuck slave stalls the arbiter indefinitely.

Test Plan:
- Reset: wb_rst_n_i=0 for 2 cycles with m_cyc_i=2'b11 -> grant_o=0 and s_cyc_o=0 during reset; master 0 granted 1 cycle after reset release.
- Round-robin: both masters hold single reads to 0x100 / 0x2000 back-to-back -> grant order 0,1,0,1; one idle cycle between owners; m_ack_o never asserted to the non-granted master.
- Burst: master 1 issues a 4-beat cti=010 burst at 0x40 while master 0 requests -> all 4 acks go to master 1, adr 0x40..0x4C forwarded in order, master 0 granted only after master 1's cyc drops.
- Single requester: only master 1 requests 3 times consecutively -> granted each time with 1-cycle latency, master 0 lines untouched.
- Reset mid-burst: wb_rst_n_i=0 on beat 2 of a 4-beat burst -> next edge s_cyc_o=0, grant_o=0, last=NUM_MASTERS-1.
- Watchdog (macro defined, TIMEOUT=8): slave never acks -> after 8 stalled cycles a single-cycle m_err_o[granted]=1, s_cyc_o=0, and the arbiter returns to IDLE once the master drops cyc.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone B3 arbiter sharing one slave among NUM_MASTERS masters.
//
// Ports:
//   wb_clk_i, wb_rst_n_i     clock, synchronous active-low reset
//   m_*_i                    flattened master requests, master k at slice k
//   m_dat_o                  slave read data broadcast to every master slice
//   m_ack_o/m_err_o/m_rty_o  slave responses routed to the granted master only
//   s_*_o / s_*_i            single slave port, driven from the granted master
//   grant_o                  registered one-hot grant
//   busy_o                   high whenever the arbiter is not IDLE
//
// Optional: define WB_RR_ARBITER_WATCHDOG_EN to add a stall watchdog that aborts
// a cycle with an error after TIMEOUT unanswered strobe cycles.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_n_i,
  input  logic [AW*NUM_MASTERS-1:0]     m_adr_i,
  input  logic [DW*NUM_MASTERS-1:0]     m_dat_i,
  input  logic [(DW/8)*NUM_MASTERS-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [3*NUM_MASTERS-1:0]      m_cti_i,
  input  logic [2*NUM_MASTERS-1:0]      m_bte_i,
  output logic [DW*NUM_MASTERS-1:0]     m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [NUM_MASTERS-1:0]        m_rty_o,
  output logic [AW-1:0]                 s_adr_o,
  output logic [DW-1:0]                 s_dat_o,
  output logic [DW/8-1:0]               s_sel_o,
  output logic                          s_we_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic [2:0]                    s_cti_o,
  output logic [1:0]                    s_bte_o,
  input  logic [DW-1:0]                 s_dat_i,
  input  logic                          s_ack_i,
  input  logic                          s_err_i,
  input  logic                          s_rty_i,
  output logic [NUM_MASTERS-1:0]        grant_o,
  output logic                          busy_o
);
`ifdef WB_RR_ARBITER_WATCHDOG_EN
  localparam int IW = $clog2(NUM_MASTERS);
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;
`else
  // TIMEOUT has no effect without the watchdog; it only keeps the parameter list identical.
  localparam int IW = $clog2(NUM_MASTERS) + 0 * TIMEOUT;
  typedef enum logic {IDLE, GRANT} state_t;
`endif
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d, sel;
  logic [IW-1:0]          last_q, last_d, idx_q, idx_d, pick, cand;
  logic                   found, resp;

  assign resp    = s_ack_i | s_err_i | s_rty_i;
  assign sel     = (state_q == GRANT) ? grant_q : '0;
  assign grant_o = grant_q;
  assign busy_o  = state_q != IDLE;
  assign m_dat_o = {NUM_MASTERS{s_dat_i}};
  assign m_ack_o = sel & {NUM_MASTERS{s_ack_i}};
  assign m_rty_o = sel & {NUM_MASTERS{s_rty_i}};
`ifdef WB_RR_ARBITER_WATCHDOG_EN
  assign m_err_o = (sel & {NUM_MASTERS{s_err_i}}) | (err_q ? grant_q : '0);
`else
  assign m_err_o = sel & {NUM_MASTERS{s_err_i}};
`endif

  // Rotating priority: scan upward from the master after the last owner, with wrap.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = IW'((int'(last_q) + i) % NUM_MASTERS);
      if (!found && m_cyc_i[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Slave side is a one-hot AND-OR mux; all zeros unless a grant is live in GRANT.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (sel[k]) begin
        s_adr_o = m_adr_i[AW*k +: AW];
        s_dat_o = m_dat_i[DW*k +: DW];
        s_sel_o = m_sel_i[(DW/8)*k +: DW/8];
        s_we_o  = m_we_i[k];
        s_cyc_o = m_cyc_i[k];
        s_stb_o = m_stb_i[k];
        s_cti_o = m_cti_i[3*k +: 3];
        s_bte_o = m_bte_i[2*k +: 2];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    idx_d   = idx_q;
`ifdef WB_RR_ARBITER_WATCHDOG_EN
    wd_d    = '0;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: if (found) begin
        state_d = GRANT;
        idx_d   = pick;
        grant_d = NUM_MASTERS'(1) << pick;
      end
      // Ownership ends only on a cyc drop, so bursts are never split.
      GRANT: if (!m_cyc_i[idx_q]) begin
        state_d = IDLE;
        last_d  = idx_q;
        grant_d = '0;
      end
`ifdef WB_RR_ARBITER_WATCHDOG_EN
      else if (!resp && s_stb_o) begin
        wd_d = wd_q + 8'd1;
        if (wd_d == WD_LIMIT) begin
          state_d = ABORT;
          err_d   = 1'b1;
          wd_d    = '0;
        end
      end else if (!resp) wd_d = wd_q;
      ABORT: if (!m_cyc_i[idx_q]) begin
        state_d = IDLE;
        last_d  = idx_q;
        grant_d = '0;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

`ifdef WB_RR_ARBITER_WATCHDOG_EN
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`endif
endmodule
